// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int FETCH_PC_W = 9;
    localparam int PC_STEP    = 4;
    localparam int PC_RESET   = 0;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : 2-entry shift FIFO with flush and registered head outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter type T = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  T           i_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output T           o_head,
    output logic       o_valid,
    output logic [1:0] o_count
);

    T           r_head;
    T           r_tail;
    logic [1:0] r_count;

    // Head keeps its last value when the queue drains or is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (i_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_data;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register, in-flight tracking and credit-based issue to imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = FETCH_PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            IF_Valid,
    output logic [PC_W-1:0] IF_PC,
    output logic [31:0]     IF_Instr,
    input  logic            ID_Ready
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [PC_W-1:0] r_fetch_pc;
    logic            r_inflight;
    logic [PC_W-1:0] r_inflight_pc;

    logic            w_pop;
    logic            w_issue;
    logic [1:0]      w_count;
    logic [2:0]      w_used;
    logic [PC_W-1:0] w_target;
    entry_t          w_push_data;
    entry_t          w_head;
    logic            w_unused_brpc;

    assign w_pop    = IF_Valid && ID_Ready;
    // Slots already committed: queued words plus the outstanding response.
    assign w_used   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = !reset && !PcSel && (w_used < 3'd2);
    assign w_target = {BrPC[PC_W-1:2], 2'b00};
    assign w_unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= PC_W'(PC_RESET);
            r_inflight    <= 1'b0;
            r_inflight_pc <= PC_W'(PC_RESET);
        end else if (PcSel) begin
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + PC_W'(PC_STEP);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

    fetch_queue #(
        .T (entry_t)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (PcSel),
        .o_head  (w_head),
        .o_valid (IF_Valid),
        .o_count (w_count)
    );

    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;
    assign IF_PC     = w_head.pc;
    assign IF_Instr  = w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed scoreboard bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = 32'd0;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata = 32'd0;
    logic            IF_Valid;
    logic [PC_W-1:0] IF_PC;
    logic [31:0]     IF_Instr;
    logic            ID_Ready = 1'b0;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [PC_W-1:0] exp_q[$];

    pc_fetch_unit #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .IF_Valid   (IF_Valid),
        .IF_PC      (IF_PC),
        .IF_Instr   (IF_Instr),
        .ID_Ready   (ID_Ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [PC_W-1:0] pc);
        return 32'hE000_0000 | {{(32-PC_W){1'b0}}, pc};
    endfunction

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= instr_of(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_restart(input logic [PC_W-1:0] start);
        logic [PC_W-1:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(p);
            p = p + PC_W'(4);
        end
    endtask

    task automatic drive(input logic rst, input logic sel, input logic rdy, input logic [31:0] br);
        reset    = rst;
        PcSel    = sel;
        ID_Ready = rdy;
        BrPC     = br;
        #1;
    endtask

    task automatic tick();
        logic [PC_W-1:0] e;
        logic [PC_W-1:0] tgt;
        if (IF_Valid && ID_Ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(IF_PC), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("IF_PC", 32'(IF_PC), 32'(e));
                chk("IF_Instr", IF_Instr, instr_of(e));
            end
        end
        tgt = BrPC[PC_W-1:0];
        tgt[1:0] = 2'b00;
        if (reset) sb_restart('0);
        else if (PcSel) sb_restart(tgt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        drive(1, 0, 1, 0); tick();
        drive(1, 0, 1, 0);
        chk("rst_imem_en", 32'(imem_en), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_IF_Valid", 32'(IF_Valid), 0);
        chk("rst_IF_PC", 32'(IF_PC), 0);
        chk("rst_IF_Instr", IF_Instr, 0);
        tick();

        // First fetch and steady stream
        drive(0, 0, 1, 0);
        chk("c0_imem_en", 32'(imem_en), 1);
        chk("c0_imem_addr", 32'(imem_addr), 0);
        tick();
        drive(0, 0, 1, 0); chk("c1_IF_Valid", 32'(IF_Valid), 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0); chk("stream_valid", 32'(IF_Valid), 1); tick();
        end

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0); chk("stall_imem_en", 32'(imem_en), 0);
            if (i == 4) begin
                chk("stall_IF_Valid", 32'(IF_Valid), 1);
                chk("stall_IF_PC", 32'(IF_PC), 32'h10);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0); chk("release_valid", 32'(IF_Valid), 1); tick();
        end

        // Redirect to 0x40
        drive(0, 1, 1, 32'h40); chk("redir_imem_en", 32'(imem_en), 0); tick();
        drive(0, 0, 1, 0);
        chk("redir_n1_imem_en", 32'(imem_en), 1);
        chk("redir_n1_addr", 32'(imem_addr), 32'h40);
        chk("redir_n1_valid", 32'(IF_Valid), 0);
        tick();
        drive(0, 0, 1, 0); chk("redir_n2_valid", 32'(IF_Valid), 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0); chk("redir_valid", 32'(IF_Valid), 1); tick();
        end

        // Misaligned target and wrap
        drive(0, 1, 1, 32'h1FE); tick();
        drive(0, 0, 1, 0); chk("wrap_addr0", 32'(imem_addr), 32'h1FC); tick();
        drive(0, 0, 1, 0); chk("wrap_addr1", 32'(imem_addr), 32'h000); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0); chk("wrap_valid", 32'(IF_Valid), 1); tick();
        end

        // Back-to-back redirects with a full queue
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0); tick();
        end
        drive(0, 1, 1, 32'h100); chk("full_valid", 32'(IF_Valid), 1); tick();
        drive(0, 1, 1, 32'h80);
        chk("redir2_valid", 32'(IF_Valid), 0);
        chk("redir2_imem_en", 32'(imem_en), 0);
        tick();
        drive(0, 0, 1, 0); chk("redir2_addr", 32'(imem_addr), 32'h80); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0); tick();
        end

        // Reset mid-stream with a full queue
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0); tick();
        end
        drive(1, 0, 0, 0); chk("midrst_full", 32'(IF_Valid), 1); tick();
        drive(0, 0, 1, 0);
        chk("midrst_valid", 32'(IF_Valid), 0);
        chk("midrst_imem_en", 32'(imem_en), 1);
        chk("midrst_addr", 32'(imem_addr), 0);
        tick();
        drive(0, 0, 1, 0); chk("midrst_valid1", 32'(IF_Valid), 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0); chk("midrst_stream", 32'(IF_Valid), 1); tick();
        end

        chk("total_pops", 32'(pops), 32'd25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
